// File: rtl/i2s_panel_slicer_if.sv
// i2s_panel_slicer_if: LED panel output bundle driven by one slicer instance
interface i2s_panel_slicer_if #(parameter int CHAINS = 2, parameter int ROW_W = 6);
  logic [ROW_W-1:0]  row_num;
  logic [CHAINS-1:0] led_data;
  logic              led_clk;
  logic              led_lat;
  logic              led_oe;
  logic              addressed;
  modport master (output row_num, led_data, led_clk, led_lat, led_oe, addressed);
  modport slave  (input  row_num, led_data, led_clk, led_lat, led_oe, addressed);
endinterface

// File: rtl/i2s_panel_slicer.sv
// i2s_panel_slicer: extracts this module's slot from a framed I2S stream and drives LED chains
module i2s_panel_slicer #(
  parameter int ADDR_W   = 4,
  parameter int ROW_W    = 6,
  parameter int CHAINS   = 2,
  parameter int PIX_BITS = 8
) (
  input  logic              i2s_clk,
  input  logic              rst_n,
  input  logic              i2s_data,
  input  logic [ADDR_W-1:0] addr_x,
  input  logic [ADDR_W-1:0] addr_y,
  i2s_panel_slicer_if.master led
);
  localparam int HDR_BITS  = 2*ADDR_W+2+ROW_W;
  localparam int SLOT_BITS = CHAINS*PIX_BITS;
  localparam int BW = $clog2(HDR_BITS > SLOT_BITS ? HDR_BITS : SLOT_BITS);
  localparam int GW = $clog2(CHAINS);
  localparam int SW = 2*ADDR_W;
  typedef enum logic {HDR, PAY} state_t;
  state_t            st;
  logic [HDR_BITS-2:0] hsr;
  logic [HDR_BITS-1:0] hdr_nx;
  logic [CHAINS-2:0] grp;
  logic [CHAINS-1:0] grp_nx;
  logic [BW-1:0]     bcnt;
  logic [GW-1:0]     gcnt;
  logic [SW-1:0]     slot, last_slot, own;
  logic [ADDR_W-1:0] nx, ny;
  logic [1:0]        mode;
  logic [ROW_W-1:0]  row;
  logic [3:0]        seq;
  logic              clk_p, slot_end, grp_end, own_act;
  always_comb begin
    hdr_nx   = {hsr, i2s_data};
    grp_nx   = {grp, i2s_data};
    nx       = hdr_nx[HDR_BITS-1 -: ADDR_W];
    ny       = hdr_nx[HDR_BITS-1-ADDR_W -: ADDR_W];
    slot_end = bcnt == BW'(SLOT_BITS-1);
    grp_end  = gcnt == GW'(CHAINS-1);
    own_act  = st == PAY && led.addressed && slot == own && !mode[1];
  end
  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= HDR;
      hsr           <= '0;
      grp           <= '0;
      bcnt          <= '0;
      gcnt          <= '0;
      slot          <= '0;
      last_slot     <= '0;
      own           <= '0;
      mode          <= '0;
      row           <= '0;
      seq           <= '0;
      clk_p         <= 1'b0;
      led.row_num   <= '0;
      led.led_data  <= '0;
      led.led_clk   <= 1'b0;
      led.led_lat   <= 1'b0;
      led.led_oe    <= 1'b1;
      led.addressed <= 1'b0;
    end else begin
      hsr         <= hdr_nx[HDR_BITS-2:0];
      grp         <= grp_nx[CHAINS-2:0];
      seq         <= {seq[2:0], 1'b0};
      clk_p       <= 1'b0;
      led.led_clk <= clk_p;
      led.led_lat <= seq[2] && mode == 2'b00;
      if (seq[1]) led.led_oe <= 1'b1;
      if (seq[2] && mode == 2'b00) led.row_num <= row;
      if (seq[3] && mode == 2'b00) led.led_oe <= 1'b0;
      if (st == HDR) begin
        gcnt <= '0;
        bcnt <= bcnt == BW'(HDR_BITS-1) ? '0 : bcnt + BW'(1);
        if (bcnt == BW'(HDR_BITS-1)) begin
          st            <= PAY;
          slot          <= '0;
          mode          <= hdr_nx[ROW_W+1:ROW_W];
          row           <= hdr_nx[ROW_W-1:0];
          last_slot     <= (SW'(nx) + SW'(1)) * (SW'(ny) + SW'(1)) - SW'(1);
          own           <= SW'(addr_y) * (SW'(nx) + SW'(1)) + SW'(addr_x);
          led.addressed <= addr_x <= nx && addr_y <= ny;
        end
      end else begin
        gcnt <= grp_end ? '0 : gcnt + GW'(1);
        bcnt <= slot_end ? '0 : bcnt + BW'(1);
        if (slot_end) slot <= slot + SW'(1);
        if (slot_end && slot == last_slot) st <= HDR;
        if (own_act && !mode[0] && grp_end) begin
          led.led_data <= grp_nx;
          clk_p        <= 1'b1;
        end
        if (own_act && slot_end) seq <= 4'b0001;
      end
    end
  end
endmodule

// File: tb/tb_i2s_panel_slicer.sv
// tb_i2s_panel_slicer: three slicers on one stream checked cycle by cycle against a frame-level model
module tb_i2s_panel_slicer;
  localparam int NMAX = 4096;
  localparam int SB   = 16;
  localparam logic [31:0] RST_W = 32'h2;
  logic i2s_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic i2s_data = 1'b0;
  always #5 i2s_clk = ~i2s_clk;
  i2s_panel_slicer_if #(.CHAINS(2), .ROW_W(6)) b0 ();
  i2s_panel_slicer_if #(.CHAINS(2), .ROW_W(6)) b1 ();
  i2s_panel_slicer_if #(.CHAINS(2), .ROW_W(6)) b2 ();
  i2s_panel_slicer u0 (.i2s_clk(i2s_clk), .rst_n(rst_n), .i2s_data(i2s_data), .addr_x(4'd0), .addr_y(4'd0), .led(b0));
  i2s_panel_slicer u1 (.i2s_clk(i2s_clk), .rst_n(rst_n), .i2s_data(i2s_data), .addr_x(4'd1), .addr_y(4'd0), .led(b1));
  i2s_panel_slicer u2 (.i2s_clk(i2s_clk), .rst_n(rst_n), .i2s_data(i2s_data), .addr_x(4'd2), .addr_y(4'd0), .led(b2));
  int total = 0;
  int bad   = 0;
  int cyc   = -1;
  int fp;
  logic stream[$];
  int e_row[3][NMAX], e_data[3][NMAX], e_oe[3][NMAX], e_adr[3][NMAX];
  bit e_clk[3][NMAX], e_lat[3][NMAX];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [31:0] out_word(input int i);
    case (i)
      0: return {20'b0, b0.row_num, b0.led_data, b0.led_clk, b0.led_lat, b0.led_oe, b0.addressed};
      1: return {20'b0, b1.row_num, b1.led_data, b1.led_clk, b1.led_lat, b1.led_oe, b1.addressed};
      default: return {20'b0, b2.row_num, b2.led_data, b2.led_clk, b2.led_lat, b2.led_oe, b2.addressed};
    endcase
  endfunction
  function automatic logic [31:0] exp_word(input int i, input int t);
    return {20'b0, 6'(e_row[i][t]), 2'(e_data[i][t]), e_clk[i][t], e_lat[i][t], 1'(e_oe[i][t]), 1'(e_adr[i][t])};
  endfunction
  task automatic add_frame(input logic [15:0] h, input logic [31:0] pay, input bit use_pay);
    int n;
    n = (int'(h[15:12]) + 1) * (int'(h[11:8]) + 1) * SB;
    for (int b = 15; b >= 0; b--) stream.push_back(h[b]);
    for (int b = 0; b < n; b++) stream.push_back(use_pay && b < 32 ? pay[31-b] : 1'($urandom));
  endtask
  task automatic set_from(input int k, input int i, input int t, input int v);
    for (int j = t; j < NMAX; j++)
      case (k)
        0: e_row[i][j] = v;
        1: e_data[i][j] = v;
        2: e_oe[i][j] = v;
        default: e_adr[i][j] = v;
      endcase
  endtask
  task automatic build();
    int p, nx, ny, md, rw, s, st, e, l;
    logic [15:0] h;
    bit adr;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < NMAX; j++) begin
        e_row[i][j] = 0; e_data[i][j] = 0; e_oe[i][j] = 1; e_adr[i][j] = 0;
        e_clk[i][j] = 0; e_lat[i][j] = 0;
      end
    p = 0;
    while (p < stream.size()) begin
      for (int b = 0; b < 16; b++) h = {h[14:0], stream[p+b]};
      nx = int'(h[15:12]); ny = int'(h[11:8]); md = int'(h[7:6]); rw = int'(h[5:0]);
      for (int i = 0; i < 3; i++) begin
        adr = i <= nx;
        set_from(3, i, p + 15, int'(adr));
        if (adr && md < 2) begin
          s  = i;
          st = p + 16 + s * SB;
          l  = st + SB - 1;
          if (md == 0)
            for (int k = 0; k < SB / 2; k++) begin
              e = st + 2 * k + 1;
              set_from(1, i, e, int'({stream[e-1], stream[e]}));
              if (e + 1 < NMAX) e_clk[i][e+1] = 1'b1;
            end
          set_from(2, i, l + 2, 1);
          if (md == 0) begin
            if (l + 3 < NMAX) e_lat[i][l+3] = 1'b1;
            set_from(0, i, l + 3, rw);
            set_from(2, i, l + 4, 0);
          end
        end
      end
      p += 16 + (nx + 1) * (ny + 1) * SB;
    end
  endtask
  initial begin
    logic [15:0] jh;
    logic [15:0] d0, d1;
    int c0, c1, c2, l0, l1, l2, stop;
    logic o0, o1, o2;
    d0 = '0; d1 = '0; c0 = 0; c1 = 0; c2 = 0; l0 = 0; l1 = 0; l2 = 0; o0 = 0; o1 = 0; o2 = 0;
    repeat (3) @(negedge i2s_clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_u%0d", i), out_word(i), RST_W);
    jh = 16'h1000;
    rst_n = 1'b1;
    for (int b = 0; b < 26; b++) begin
      i2s_data = b < 16 ? jh[15-b] : 1'($urandom);
      @(negedge i2s_clk);
    end
    #2 rst_n = 1'b0;
    #1 for (int i = 0; i < 3; i++) chk($sformatf("rst_mid_u%0d", i), out_word(i), RST_W);
    repeat (2) begin
      @(negedge i2s_clk);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_hold_u%0d", i), out_word(i), RST_W);
    end
    add_frame(16'h1000, 32'hA5C30F96, 1'b1);
    add_frame(16'h1001, 32'h0, 1'b0);
    add_frame(16'h1041, 32'h0, 1'b0);
    add_frame(16'h1002, 32'h0, 1'b0);
    add_frame(16'h10C0, 32'h0, 1'b0);
    add_frame(16'h1003, 32'h0, 1'b0);
    for (int f = 0; f < 20; f++)
      add_frame({4'($urandom_range(0, 2)), 4'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom)}, 32'h0, 1'b0);
    fp = stream.size();
    add_frame(16'h1005, 32'h0, 1'b0);
    build();
    stop = fp + 31 + 2;
    @(negedge i2s_clk);
    rst_n = 1'b1;
    i2s_data = stream[0];
    for (int t = 0; t <= stop; t++) begin
      @(negedge i2s_clk);
      cyc = t;
      for (int i = 0; i < 3; i++) chk($sformatf("u%0d", i), out_word(i), exp_word(i, t));
      if (t < 60) begin
        if (b0.led_clk) begin c0++; d0 = {d0[13:0], b0.led_data}; end
        if (b1.led_clk) begin c1++; d1 = {d1[13:0], b1.led_data}; end
        if (b2.led_clk) c2++;
        if (b0.led_lat) l0++;
        if (b1.led_lat) l1++;
        if (b2.led_lat) l2++;
      end
      if (t == 59) begin o0 = b0.led_oe; o1 = b1.led_oe; o2 = b2.led_oe; end
      if (t + 1 < stream.size()) i2s_data = stream[t+1];
    end
    chk("f1_clk_u0", c0, 8);
    chk("f1_clk_u1", c1, 8);
    chk("f1_clk_u2", c2, 0);
    chk("f1_data_u0", d0, 16'hA5C3);
    chk("f1_data_u1", d1, 16'h0F96);
    chk("f1_lat_u0", l0, 1);
    chk("f1_lat_u1", l1, 1);
    chk("f1_lat_u2", l2, 0);
    chk("f1_oe_u0", o0, 0);
    chk("f1_oe_u1", o1, 0);
    chk("f1_oe_u2", o2, 1);
    #2 rst_n = 1'b0;
    #1 for (int i = 0; i < 3; i++) chk($sformatf("rst_lat_u%0d", i), out_word(i), RST_W);
    repeat (3) begin
      @(negedge i2s_clk);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_lat_hold_u%0d", i), out_word(i), RST_W);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
